// File: rtl/sad_min_finder.sv
// sad_min_finder
// Scans a result SRAM from address 0 up to a latched last address and reports
// the smallest unsigned value found and the address where it first occurs.
//
// Ports
//   Clk        in   single clock, all state changes on the rising edge
//   Rst        in   asynchronous active-high reset
//   Go         in   start request, only looked at while idle
//   Last_Addr  in   highest address to scan, captured when Go is accepted
//   Sram_Data  in   SRAM read data, valid one edge after the read is issued
//   Addr       out  SRAM address
//   En         out  SRAM enable
//   RW         out  SRAM read/write select, tied to read (0)
//   Min_Value  out  smallest value of the last completed scan
//   Min_Index  out  address of Min_Value (lowest address on ties)
//   Busy       out  high while a scan is in progress
//   Done       out  one-cycle pulse when a scan completes
module sad_min_finder #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Go,
    input  logic [ADDR_WIDTH-1:0] Last_Addr,
    input  logic [DATA_WIDTH-1:0] Sram_Data,
    output logic [ADDR_WIDTH-1:0] Addr,
    output logic                  En,
    output logic                  RW,
    output logic [DATA_WIDTH-1:0] Min_Value,
    output logic [ADDR_WIDTH-1:0] Min_Index,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  en_q, en_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    // valid_q marks the cycle in which Sram_Data holds the word addressed by
    // smp_idx_q (both are the previous cycle's En/Addr).
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] smp_idx_q, smp_idx_d;
    logic [DATA_WIDTH-1:0] run_val_q, run_val_d;
    logic [ADDR_WIDTH-1:0] run_idx_q, run_idx_d;
    logic [DATA_WIDTH-1:0] min_val_q, min_val_d;
    logic [ADDR_WIDTH-1:0] min_idx_q, min_idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // State register and all datapath flops, cleared asynchronously by Rst.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            en_q      <= 1'b0;
            last_q    <= '0;
            valid_q   <= 1'b0;
            smp_idx_q <= '0;
            run_val_q <= '0;
            run_idx_q <= '0;
            min_val_q <= '0;
            min_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            en_q      <= en_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            smp_idx_q <= smp_idx_d;
            run_val_q <= run_val_d;
            run_idx_q <= run_idx_d;
            min_val_q <= min_val_d;
            min_idx_q <= min_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, address sequencing and running-minimum update.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        en_d      = 1'b0;
        last_d    = last_q;
        valid_d   = en_q;
        smp_idx_d = addr_q;
        run_val_d = run_val_q;
        run_idx_d = run_idx_q;
        min_val_d = min_val_q;
        min_idx_d = min_idx_q;

        // Sample 0 seeds the running minimum; later samples replace it only
        // when strictly smaller, so the earliest address wins a tie.
        if (valid_q) begin
            if ((smp_idx_q == {ADDR_WIDTH{1'b0}}) || (Sram_Data < run_val_q)) begin
                run_val_d = Sram_Data;
                run_idx_d = smp_idx_q;
            end else begin
                run_val_d = run_val_q;
                run_idx_d = run_idx_q;
            end
        end else begin
            run_val_d = run_val_q;
            run_idx_d = run_idx_q;
        end

        case (state_q)
            IDLE: begin
                if (Go) begin
                    state_d = READ;
                    last_d  = Last_Addr;
                    addr_d  = {ADDR_WIDTH{1'b0}};
                    en_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                // Stop at the last address instead of incrementing, so Addr
                // never passes it and never wraps.
                if (addr_q == last_q) begin
                    state_d = WAIT;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    en_d   = 1'b1;
                end
            end
            WAIT: begin
                // The final sample is compared on this same edge, so publish
                // the already-updated running values.
                state_d   = DONE;
                min_val_d = run_val_d;
                min_idx_d = run_idx_d;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign Addr      = addr_q;
    assign En        = en_q;
    assign RW        = 1'b0;
    assign Min_Value = min_val_q;
    assign Min_Index = min_idx_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_sad_min_finder.sv
// Testbench for sad_min_finder: directed table of scans, randomized scans
// against a behavioural minimum search, async reset and mid-scan abort.
module tb_sad_min_finder;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          Clk;
    logic          Rst;
    logic          Go;
    logic [AW-1:0] Last_Addr;
    logic [DW-1:0] Sram_Data;
    logic [AW-1:0] Addr;
    logic          En;
    logic          RW;
    logic [DW-1:0] Min_Value;
    logic [AW-1:0] Min_Index;
    logic          Busy;
    logic          Done;

    logic [DW-1:0] mem [128];

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] prev_min;
    logic [AW-1:0] prev_idx;

    sad_min_finder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Go        (Go),
        .Last_Addr (Last_Addr),
        .Sram_Data (Sram_Data),
        .Addr      (Addr),
        .En        (En),
        .RW        (RW),
        .Min_Value (Min_Value),
        .Min_Index (Min_Index),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SRAM model: registered read, drives 0 when not enabled.
    always @(posedge Clk) begin
        if (En) Sram_Data <= mem[Addr];
        else    Sram_Data <= '0;
    end

    typedef struct {
        int            l;
        int            pat;
        logic [DW-1:0] exp_min;
        logic [AW-1:0] exp_idx;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain linear search, first occurrence of the minimum.
    task automatic ref_min(input int l, output logic [DW-1:0] v, output logic [AW-1:0] ix);
        v  = mem[0];
        ix = '0;
        for (int i = 1; i <= l; i++) begin
            if (mem[i] < v) begin
                v  = mem[i];
                ix = AW'(i);
            end
        end
    endtask

    task automatic fill(input int pat, input int l);
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        case (pat)
            0: begin mem[0] = 32'd50; mem[1] = 32'd20; mem[2] = 32'd30; mem[3] = 32'd20; end
            1: mem[0] = 32'd7;
            2: for (int i = 0; i < 128; i++) mem[i] = 32'd1000 - 32'(i);
            3: for (int i = 0; i <= l; i++) mem[i] = 32'hFFFF_FFFF;
            default: begin
                for (int i = 0; i <= l; i++)
                    mem[i] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 12)) : $urandom;
            end
        endcase
    endtask

    // Runs one scan, checking Addr/En/Busy/Done per cycle, latency L+2,
    // held results during the scan and final results. go_mid >= 0 pulses Go
    // in that scan cycle.
    task automatic scan(input int l, input int go_mid, input logic [DW-1:0] emin,
                        input logic [AW-1:0] eidx);
        @(negedge Clk);
        Go        = 1'b1;
        Last_Addr = AW'(l);
        @(posedge Clk);
        #1;
        Go = 1'b0;
        for (int j = 0; j <= l + 1; j++) begin
            if (j <= l) begin
                chk("read_en", {63'd0, En}, 64'd1);
                chk("read_addr", {57'd0, Addr}, 64'(j));
            end else begin
                chk("wait_en", {63'd0, En}, 64'd0);
                chk("wait_addr_hold", {57'd0, Addr}, 64'(l));
            end
            chk("busy", {63'd0, Busy}, 64'd1);
            chk("no_early_done", {63'd0, Done}, 64'd0);
            chk("min_held", {32'd0, Min_Value}, {32'd0, prev_min});
            chk("idx_held", {57'd0, Min_Index}, {57'd0, prev_idx});
            Go = (j == go_mid) ? 1'b1 : 1'b0;
            @(posedge Clk);
            #1;
        end
        Go = 1'b0;
        chk("done_pulse", {63'd0, Done}, 64'd1);
        chk("done_en", {63'd0, En}, 64'd0);
        chk("min_value", {32'd0, Min_Value}, {32'd0, emin});
        chk("min_index", {57'd0, Min_Index}, {57'd0, eidx});
        chk("rw", {63'd0, RW}, 64'd0);
        @(posedge Clk);
        #1;
        chk("done_one_cycle", {63'd0, Done}, 64'd0);
        chk("idle_busy", {63'd0, Busy}, 64'd0);
        chk("idle_addr_hold", {57'd0, Addr}, 64'(l));
        chk("min_stable", {32'd0, Min_Value}, {32'd0, emin});
        prev_min = emin;
        prev_idx = eidx;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_addr"}, {57'd0, Addr}, 64'd0);
        chk({tag, "_en"}, {63'd0, En}, 64'd0);
        chk({tag, "_busy"}, {63'd0, Busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, Done}, 64'd0);
        chk({tag, "_minv"}, {32'd0, Min_Value}, 64'd0);
        chk({tag, "_mini"}, {57'd0, Min_Index}, 64'd0);
        chk({tag, "_rw"}, {63'd0, RW}, 64'd0);
    endtask

    initial begin
        vec_t vecs [4];
        logic [DW-1:0] rv;
        logic [AW-1:0] ri;
        int l;
        bit done_seen;

        vecs[0] = '{l: 3,   pat: 0, exp_min: 32'd20,        exp_idx: 7'd1};
        vecs[1] = '{l: 0,   pat: 1, exp_min: 32'd7,         exp_idx: 7'd0};
        vecs[2] = '{l: 127, pat: 2, exp_min: 32'd873,       exp_idx: 7'd127};
        vecs[3] = '{l: 15,  pat: 3, exp_min: 32'hFFFF_FFFF, exp_idx: 7'd0};

        Rst       = 1'b1;
        Go        = 1'b0;
        Last_Addr = '0;
        Sram_Data = '0;
        prev_min  = '0;
        prev_idx  = '0;
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        #1;
        chk_zero_outputs("por");
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        // Directed table.
        for (int v = 0; v < 4; v++) begin
            fill(vecs[v].pat, vecs[v].l);
            scan(vecs[v].l, -1, vecs[v].exp_min, vecs[v].exp_idx);
        end

        // Async reset between edges while idle with non-zero results.
        fill(0, 3);
        scan(3, -1, 32'd20, 7'd1);
        @(posedge Clk);
        #3;
        Rst = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        @(negedge Clk);
        Rst = 1'b0;
        prev_min = '0;
        prev_idx = '0;

        // Go pulsed during READ has no effect.
        fill(0, 3);
        scan(3, 1, 32'd20, 7'd1);

        // Mid-scan abort at scan cycle 3.
        fill(2, 127);
        @(negedge Clk);
        Go        = 1'b1;
        Last_Addr = 7'd10;
        @(posedge Clk);
        #1;
        Go = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        Rst = 1'b1;
        #1;
        chk_zero_outputs("abort");
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        done_seen = 1'b0;
        repeat (20) begin
            @(posedge Clk);
            #1;
            if (Done) done_seen = 1'b1;
        end
        chk("abort_no_done", {63'd0, done_seen}, 64'd0);
        chk_zero_outputs("abort_after");
        prev_min = '0;
        prev_idx = '0;

        // Next Go after reset scans normally.
        fill(0, 3);
        scan(3, -1, 32'd20, 7'd1);

        // Randomized scans against the reference search.
        for (int r = 0; r < 10; r++) begin
            l = (r == 0) ? 0 : $urandom_range(0, 127);
            fill(9, l);
            ref_min(l, rv, ri);
            scan(l, (r % 3 == 0) ? $urandom_range(0, l) : -1, rv, ri);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sad_min_finder.md
SAD_MIN_FINDER -- requirements
Module: sad_min_finder

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, SHALL be the result-SRAM address width (up to 128 entries).
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be the SAD result width.
REQ-003 Clk  input  1  SHALL be the single clock; all state changes on posedge Clk.
REQ-004 Rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Go  input  1  SHALL be the start request, sampled only in IDLE.
REQ-006 Last_Addr  input  ADDR_WIDTH  SHALL be the highest address scanned; it is sampled on the Go-accept edge.
REQ-007 Sram_Data  input  DATA_WIDTH  SHALL be the result-SRAM read data, registered by the SRAM one edge after the read is issued.
REQ-008 Addr  output  ADDR_WIDTH  SHALL be the result-SRAM address.
REQ-009 En  output  1  SHALL be the result-SRAM enable.
REQ-010 RW  output  1  SHALL be the result-SRAM read/write select; it is constant 0 (read only).
REQ-011 Min_Value  output  DATA_WIDTH  SHALL be the smallest SAD found.
REQ-012 Min_Index  output  ADDR_WIDTH  SHALL be the address of Min_Value.
REQ-013 Busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-014 Done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, READ, WAIT and DONE, with transitions IDLE->READ on Go=1, READ->WAIT when the read of Last_Addr issues, WAIT->DONE unconditionally, and DONE->IDLE unconditionally.
REQ-016 Go accept at edge E0 SHALL latch Last_Addr as L and drive Addr=0, En=1 during the following cycle.
REQ-017 In READ, Addr SHALL increment by 1 per cycle from 0 to L with En=1; Addr SHALL never exceed L and SHALL never wrap.
REQ-018 En SHALL be 0 in IDLE, WAIT and DONE; Addr SHALL hold its last value outside READ.
REQ-019 A one-cycle-delayed valid flag SHALL mark cycles in which Sram_Data holds mem[k]; each valid sample SHALL be compared at the next edge.
REQ-020 The first valid sample (k=0) of a scan SHALL load unconditionally: running value = Sram_Data, running index = 0.
REQ-021 Each later sample SHALL replace the running minimum only if it is strictly less, using an unsigned DATA_WIDTH compare, so the lowest index wins on ties.
REQ-022 Done SHALL be high for exactly the one cycle after edge E0+L+2, so latency from the Go-accept edge is L+2 edges.
REQ-023 Min_Value and Min_Index SHALL be updated from the running registers on the edge entering DONE and SHALL hold until the next DONE, so they are stable during a new scan.
REQ-024 Go SHALL be ignored in READ, WAIT and DONE; a scan SHALL never restart or queue.
REQ-025 L=0 SHALL give a one-cycle READ, with Done asserted 2 edges after Go.
REQ-026 Sram_Data SHALL be ignored in any cycle whose valid flag is low, since the SRAM drives 0 when it is not reading.

Reset
REQ-027 Rst=1 SHALL immediately, without waiting for Clk, force IDLE and set Addr=0, En=0, RW=0, Busy=0, Done=0, Min_Value=0, Min_Index=0, and clear the valid flag and running registers.
REQ-028 Rst asserted mid-scan SHALL abort the scan, produce no Done pulse, and leave outputs at their reset values.
REQ-029 The first Go sampled after Rst deasserts SHALL start a normal scan.

Verification
REQ-030 Reset test: assert Rst asynchronously between edges -> all outputs 0 before the next edge, state IDLE.
REQ-031 Basic scan: L=3, mem={50,20,30,20} -> Addr sequence 0,1,2,3 with En=1 for 4 cycles, then Done 5 edges after Go, Min_Value=20, Min_Index=1.
REQ-032 Single entry: L=0, mem[0]=7 -> Done 2 edges after Go, Min_Value=7, Min_Index=0.
REQ-033 Full range: L=127, mem[i]=1000-i -> Min_Value=873, Min_Index=127, Done 129 edges after Go, Addr stays 127 after READ with no wrap.
REQ-034 All-max values: L=15, every mem=32'hFFFFFFFF -> Min_Value=32'hFFFFFFFF, Min_Index=0.
REQ-035 Busy and abort: Go pulsed during READ -> no effect and a single Done; a second run with Rst pulsed at scan cycle 3 -> no Done, outputs 0, and the next Go scans correctly.
